// File: rtl/vote_tally_ctrl.sv
// Vote tally controller: one vote per press, lockout between ballots.
// Optional VOTE_SATURATE_EN: tallies stick at 15 instead of wrapping.
module vote_tally_ctrl #(
  parameter int NUM_CAND    = 4,
  parameter int LOCKOUT_CYC = 8
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  enable,
  input  logic [NUM_CAND-1:0]   vote_btn,
  output logic                  busy,
  output logic                  vote_ack,
  output logic                  vote_err,
  output logic                  overflow,
  output logic [7:0]            total_votes,
  output logic [NUM_CAND*4-1:0] tally_flat
);

  localparam int SW = (NUM_CAND > 1) ? $clog2(NUM_CAND) : 1;
  localparam int CW = $clog2(LOCKOUT_CYC + 1);
  localparam logic [CW-1:0] CNT_LOAD = CW'(LOCKOUT_CYC - 1);

  typedef enum logic [1:0] {
    S_IDLE,
    S_ADD,
    S_LOCK
  } state_t;

  state_t        state_q, state_d;
  logic [SW-1:0] sel_q, sel_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [3:0]    tally_q [NUM_CAND];
  logic [3:0]    tally_d [NUM_CAND];
  logic [7:0]    total_q, total_d;
  logic          ovf_q, ovf_d;
  logic          ack_q, ack_d;
  logic          err_q, err_d;

  logic          press;
  logic          onehot;
  logic [SW-1:0] btn_idx;
  logic [3:0]    add_a;
  logic [3:0]    add_sum;
  logic          add_co;
  logic [7:0]    total_inc;

  assign press  = enable && (vote_btn != '0);
  assign onehot = (vote_btn & (vote_btn - NUM_CAND'(1))) == '0;

  always_comb begin
    btn_idx = '0;
    for (int i = 0; i < NUM_CAND; i++) begin
      if (vote_btn[i]) btn_idx = SW'(i);
    end
  end

  // adder_4bit datapath: a = selected tally, b = 1
  assign add_a = tally_q[sel_q];
  assign {add_co, add_sum} = {1'b0, add_a} + 5'd1;

  assign total_inc = (total_q == 8'hFF) ? total_q : total_q + 8'd1;

  always_comb begin
    state_d = state_q;
    sel_d   = sel_q;
    cnt_d   = cnt_q;
    tally_d = tally_q;
    total_d = total_q;
    ovf_d   = ovf_q;
    ack_d   = 1'b0;
    err_d   = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (press) begin
          if (onehot) begin
            sel_d   = btn_idx;
            state_d = S_ADD;
          end else begin
            err_d   = 1'b1;
            cnt_d   = CNT_LOAD;
            state_d = S_LOCK;
          end
        end
      end
      S_ADD: begin
        cnt_d   = CNT_LOAD;
        state_d = S_LOCK;
`ifdef VOTE_SATURATE_EN
        if (add_co) begin
          err_d = 1'b1;
          ovf_d = 1'b1;
        end else begin
          tally_d[sel_q] = add_sum;
          total_d        = total_inc;
          ack_d          = 1'b1;
        end
`else
        tally_d[sel_q] = add_sum;
        total_d        = total_inc;
        ack_d          = 1'b1;
        if (add_co) ovf_d = 1'b1;
`endif
      end
      S_LOCK: begin
        if (cnt_q != '0) begin
          cnt_d = cnt_q - CW'(1);
        end else if (vote_btn == '0) begin
          state_d = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_IDLE;
      sel_q   <= '0;
      cnt_q   <= '0;
      for (int i = 0; i < NUM_CAND; i++) tally_q[i] <= '0;
      total_q <= '0;
      ovf_q   <= 1'b0;
      ack_q   <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      sel_q   <= sel_d;
      cnt_q   <= cnt_d;
      tally_q <= tally_d;
      total_q <= total_d;
      ovf_q   <= ovf_d;
      ack_q   <= ack_d;
      err_q   <= err_d;
    end
  end

  assign busy        = (state_q != S_IDLE);
  assign vote_ack    = ack_q;
  assign vote_err    = err_q;
  assign overflow    = ovf_q;
  assign total_votes = total_q;

  for (genvar gi = 0; gi < NUM_CAND; gi++) begin : g_flat
    assign tally_flat[4*gi +: 4] = tally_q[gi];
  end

endmodule

// File: tb/tb_vote_tally_ctrl.sv
// Directed bench for vote_tally_ctrl (NUM_CAND=4, LOCKOUT_CYC=8).
// Table of per-cycle vectors plus hand-written multi-cycle sequences.
module tb_vote_tally_ctrl;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        enable = 1'b0;
  logic [3:0]  vote_btn = '0;
  logic        busy;
  logic        vote_ack;
  logic        vote_err;
  logic        overflow;
  logic [7:0]  total_votes;
  logic [15:0] tally_flat;

  int n_cmp = 0;
  int n_bad = 0;

  vote_tally_ctrl #(
    .NUM_CAND   (4),
    .LOCKOUT_CYC(8)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .enable     (enable),
    .vote_btn   (vote_btn),
    .busy       (busy),
    .vote_ack   (vote_ack),
    .vote_err   (vote_err),
    .overflow   (overflow),
    .total_votes(total_votes),
    .tally_flat (tally_flat)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        rst;
    logic        en;
    logic [3:0]  btn;
    logic        busy;
    logic        ack;
    logic        err;
    logic        ovf;
    logic [7:0]  total;
    logic [15:0] tally;
  } vec_t;

  vec_t tbl [64];
  int   n_vec = 0;

  task automatic add(input logic r, input logic e, input logic [3:0] b,
                     input logic bz, input logic a, input logic er,
                     input logic o, input logic [7:0] t,
                     input logic [15:0] ty);
    tbl[n_vec] = '{r, e, b, bz, a, er, o, t, ty};
    n_vec++;
  endtask

  task automatic chk(input string name, input logic [31:0] act,
                     input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic step(input logic r, input logic e, input logic [3:0] b);
    rst      = r;
    enable   = e;
    vote_btn = b;
    @(posedge clk);
    #1;
  endtask

  task automatic vote(input logic [3:0] b, output int acks,
                      output int errs);
    int k;
    acks = 0;
    errs = 0;
    step(0, 1, b);
    acks += int'(vote_ack);
    errs += int'(vote_err);
    step(0, 1, 4'b0);
    acks += int'(vote_ack);
    errs += int'(vote_err);
    k = 0;
    while (busy && k < 50) begin
      step(0, 1, 4'b0);
      acks += int'(vote_ack);
      errs += int'(vote_err);
      k++;
    end
    chk("vote_idle_timeout", 32'(busy), 32'd0);
  endtask

  initial begin
    int acks, errs, a1, e1;

    add(1, 0, 4'b0000, 0, 0, 0, 0, 0, 16'h0000);
    add(0, 1, 4'b0100, 1, 0, 0, 0, 0, 16'h0000);
    add(0, 1, 4'b0000, 1, 1, 0, 0, 1, 16'h0100);
    for (int i = 0; i < 7; i++)
      add(0, 1, 4'b0000, 1, 0, 0, 0, 1, 16'h0100);
    add(0, 1, 4'b0000, 0, 0, 0, 0, 1, 16'h0100);
    add(0, 1, 4'b0011, 1, 0, 1, 0, 1, 16'h0100);
    for (int i = 0; i < 7; i++)
      add(0, 1, 4'b0000, 1, 0, 0, 0, 1, 16'h0100);
    add(0, 1, 4'b0000, 0, 0, 0, 0, 1, 16'h0100);
    add(0, 0, 4'b0010, 0, 0, 0, 0, 1, 16'h0100);
    add(0, 0, 4'b0010, 0, 0, 0, 0, 1, 16'h0100);
    add(0, 1, 4'b0010, 1, 0, 0, 0, 1, 16'h0100);
    add(0, 0, 4'b0000, 1, 1, 0, 0, 2, 16'h0110);
    add(0, 1, 4'b0011, 1, 0, 0, 0, 2, 16'h0110);
    for (int i = 0; i < 6; i++)
      add(0, 1, 4'b0000, 1, 0, 0, 0, 2, 16'h0110);
    add(0, 1, 4'b0000, 0, 0, 0, 0, 2, 16'h0110);

    for (int i = 0; i < n_vec; i++) begin
      step(tbl[i].rst, tbl[i].en, tbl[i].btn);
      chk($sformatf("v%0d_busy", i), 32'(busy), 32'(tbl[i].busy));
      chk($sformatf("v%0d_ack", i), 32'(vote_ack), 32'(tbl[i].ack));
      chk($sformatf("v%0d_err", i), 32'(vote_err), 32'(tbl[i].err));
      chk($sformatf("v%0d_ovf", i), 32'(overflow), 32'(tbl[i].ovf));
      chk($sformatf("v%0d_total", i), 32'(total_votes), 32'(tbl[i].total));
      chk($sformatf("v%0d_tally", i), 32'(tally_flat), 32'(tbl[i].tally));
    end

    // Held button: a single vote, no return to IDLE until release
    acks = 0;
    errs = 0;
    for (int i = 0; i < 40; i++) begin
      step(0, 1, 4'b0001);
      acks += int'(vote_ack);
      errs += int'(vote_err);
    end
    chk("hold_acks", 32'(acks), 32'd1);
    chk("hold_errs", 32'(errs), 32'd0);
    chk("hold_busy", 32'(busy), 32'd1);
    chk("hold_tally", 32'(tally_flat), 32'h0111);
    chk("hold_total", 32'(total_votes), 32'd3);
    step(0, 1, 4'b0000);
    chk("hold_release_busy", 32'(busy), 32'd0);

    // Reset during the ADD cycle discards the vote
    step(0, 1, 4'b1000);
    chk("radd_busy", 32'(busy), 32'd1);
    step(1, 1, 4'b0000);
    chk("radd_tally", 32'(tally_flat), 32'h0000);
    chk("radd_total", 32'(total_votes), 32'd0);
    chk("radd_busy0", 32'(busy), 32'd0);
    chk("radd_ack", 32'(vote_ack), 32'd0);
    step(0, 1, 4'b0000);
    chk("radd_ack_after", 32'(vote_ack), 32'd0);
    chk("radd_idle_after", 32'(busy), 32'd0);

    // Sixteen votes for candidate 0
    acks = 0;
    errs = 0;
    for (int i = 0; i < 15; i++) begin
      vote(4'b0001, a1, e1);
      acks += a1;
      errs += e1;
    end
    chk("c0_15_tally", 32'(tally_flat), 32'h000F);
    chk("c0_15_ovf", 32'(overflow), 32'd0);
    chk("c0_15_acks", 32'(acks), 32'd15);
    vote(4'b0001, a1, e1);
`ifdef VOTE_SATURATE_EN
    chk("c0_16_tally", 32'(tally_flat), 32'h000F);
    chk("c0_16_total", 32'(total_votes), 32'd15);
    chk("c0_16_ack", 32'(a1), 32'd0);
    chk("c0_16_err", 32'(e1), 32'd1);
`else
    chk("c0_16_tally", 32'(tally_flat), 32'h0000);
    chk("c0_16_total", 32'(total_votes), 32'd16);
    chk("c0_16_ack", 32'(a1), 32'd1);
    chk("c0_16_err", 32'(e1), 32'd0);
`endif
    chk("c0_16_ovf", 32'(overflow), 32'd1);
    chk("c0_errs_before", 32'(errs), 32'd0);

`ifndef VOTE_SATURATE_EN
    // total_votes saturates at 255
    step(1, 0, 4'b0000);
    step(0, 0, 4'b0000);
    chk("sat_reset_ovf", 32'(overflow), 32'd0);
    for (int i = 0; i < 260; i++) vote(4'b0010, a1, e1);
    chk("sat_total", 32'(total_votes), 32'd255);
    chk("sat_tally", 32'(tally_flat), 32'h0040);
    chk("sat_ovf", 32'(overflow), 32'd1);
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
